uart_dmem_loader: RTL

Boot-time loader that feeds the memory stage's data-memory preload port (`en_addr_data`, `addr_data`, `data_data`). It receives bytes on a UART RX line, packs every four bytes little-endian into one 32-bit word, and issues one single-cycle write per word at consecutive word addresses starting at 0. It holds the core in stall via `core_hold_o` until `WORDS` words are loaded, then goes permanently idle until the next reset.

---
 rtl/uart_dmem_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_dmem_loader.sv
// rtl/uart_dmem_loader.sv - UART 8N1 receiver that packs little-endian bytes into words
// and preloads data memory at consecutive addresses while holding the core.
module uart_dmem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORDS        = 32
) (
  input  logic        sys_clk,
  input  logic        sys_arst,
  input  logic        rx_i,
  output logic        en_addr_data_o,
  output logic [4:0]  addr_data_o,
  output logic [31:0] data_data_o,
  output logic        core_hold_o,
  output logic        load_done_o,
  output logic        frame_err_o
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BAUD_1  = CW'(1);
  localparam logic [5:0]    WORDS_W = 6'(WORDS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [5:0]    word_cnt;
  logic [7:0]    shift;
  logic [23:0]   word_lo;

  always_ff @(posedge sys_clk or posedge sys_arst) begin
    if (sys_arst) begin
      state          <= IDLE;
      rx_meta        <= 1'b1;
      rx_sync        <= 1'b1;
      rx_prev        <= 1'b1;
      baud_cnt       <= '0;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      word_cnt       <= '0;
      shift          <= '0;
      word_lo        <= '0;
      en_addr_data_o <= 1'b0;
      addr_data_o    <= '0;
      data_data_o    <= '0;
      core_hold_o    <= 1'b1;
      load_done_o    <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      rx_meta        <= rx_i;
      rx_sync        <= rx_meta;
      rx_prev        <= rx_sync;
      en_addr_data_o <= 1'b0;
      frame_err_o    <= 1'b0;

      case (state)
        IDLE: begin
          // Edge-triggered start so a line stuck low after a framing error cannot restart.
          if (!load_done_o && rx_prev && !rx_sync) begin
            baud_cnt <= '0;
            state    <= START;
          end
        end

        START: begin
          if (baud_cnt == HALF_M1) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_sync ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_1;
          end
        end

        DATA: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt       <= '0;
            shift[bit_cnt] <= rx_sync;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_1;
          end
        end

        STOP: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            state    <= IDLE;
            if (!rx_sync) begin
              frame_err_o <= 1'b1;
              byte_cnt    <= '0;
            end else if (byte_cnt == 2'd3) begin
              // Fourth byte goes straight from the shifter into the output word.
              data_data_o    <= {shift, word_lo};
              addr_data_o    <= word_cnt[4:0];
              en_addr_data_o <= 1'b1;
              word_cnt       <= word_cnt + 6'd1;
              byte_cnt       <= '0;
              if (word_cnt + 6'd1 == WORDS_W) begin
                load_done_o <= 1'b1;
                core_hold_o <= 1'b0;
              end
            end else begin
              case (byte_cnt)
                2'd0:    word_lo[7:0]   <= shift;
                2'd1:    word_lo[15:8]  <= shift;
                default: word_lo[23:16] <= shift;
              endcase
              byte_cnt <= byte_cnt + 2'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
